// File: rtl/fas.sv
// fas: registered WIDTH-bit full adder/subtractor.
// A ripple chain of one-bit add or subtract cells produces the result; the
// sum/difference, carry/borrow-out and signed-overflow flag are captured on
// every valid cycle and held otherwise. Outputs come straight from flops.
module fas #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             s_op,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid
);

   // One-bit add cell, returns {carry_out, sum}.
   function automatic logic [1:0] add_cell(input logic ai, input logic bi, input logic ci);
      return {(ai & bi) | (ai & ci) | (bi & ci), ai ^ bi ^ ci};
   endfunction

   // One-bit subtract cell, returns {borrow_out, difference}.
   function automatic logic [1:0] sub_cell(input logic ai, input logic bi, input logic bri);
      return {(~ai & bi) | (~(ai ^ bi) & bri), ai ^ bi ^ bri};
   endfunction

   // Operands are forced to zero while idle so undriven inputs never reach the chain.
   logic [WIDTH-1:0] a_g_s;
   logic [WIDTH-1:0] b_g_s;
   logic             cin_g_s;
   logic             op_g_s;

   logic [WIDTH:0]   chain_s;   // chain_s[i] is the carry/borrow into cell i
   logic [WIDTH-1:0] res_s;
   logic [1:0]       cell_s;
   logic             ovf_s;

   logic [WIDTH-1:0] s_q,    s_d;
   logic             cout_q, cout_d;
   logic             ovf_q,  ovf_d;
   logic             vld_q,  vld_d;

   // Gate the operands with in_valid.
   always_comb begin
      a_g_s   = in_valid ? a    : {WIDTH{1'b0}};
      b_g_s   = in_valid ? b    : {WIDTH{1'b0}};
      cin_g_s = in_valid ? cin  : 1'b0;
      op_g_s  = in_valid ? s_op : 1'b0;
   end

   // Ripple the carry/borrow through WIDTH cells; overflow compares the MSB cell's in and out.
   always_comb begin
      chain_s    = {(WIDTH+1){1'b0}};
      res_s      = {WIDTH{1'b0}};
      cell_s     = 2'b00;
      chain_s[0] = cin_g_s;
      for (int i = 0; i < WIDTH; i++) begin
         cell_s         = op_g_s ? sub_cell(a_g_s[i], b_g_s[i], chain_s[i])
                                 : add_cell(a_g_s[i], b_g_s[i], chain_s[i]);
         res_s[i]       = cell_s[0];
         chain_s[i + 1] = cell_s[1];
      end
      ovf_s = chain_s[WIDTH-1] ^ chain_s[WIDTH];
   end

   // Next state: load a new result on valid input, otherwise hold the last one.
   always_comb begin
      s_d    = s_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      vld_d  = 1'b0;
      if (in_valid) begin
         s_d    = res_s;
         cout_d = chain_s[WIDTH];
         ovf_d  = ovf_s;
         vld_d  = 1'b1;
      end else begin
         vld_d  = 1'b0;
      end
   end

   // Result registers with synchronous reset taking priority over capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= {WIDTH{1'b0}};
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         vld_q  <= vld_d;
      end
   end

   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign out_valid = vld_q;

endmodule

// File: tb/tb_fas.sv
// Testbench for fas: directed table at WIDTH 1 and 8, hold/reset sequences,
// and randomized WIDTH-8 traffic checked against an arithmetic reference model.
module tb_fas;

   logic clk;
   logic rst;

   logic       iv1, a1, b1, cin1, op1;
   logic       s1, cout1, ovf1, ov1;
   logic       iv8, cin8, op8;
   logic [7:0] a8, b8, s8;
   logic       cout8, ovf8, ov8;

   int n_cmp;
   int n_err;

   fas #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1), .s_op(op1),
      .s(s1), .cout(cout1), .ovf(ovf1), .out_valid(ov1)
   );

   fas #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8), .s_op(op8),
      .s(s8), .cout(cout8), .ovf(ovf8), .out_valid(ov8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one edge and sample away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int         w;
      logic       op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t vecs[12];

   // Reference model state for the WIDTH-8 instance.
   logic [7:0] m_s;
   logic       m_c, m_o, m_v;

   task automatic model_step(input logic r, input logic iv, input logic op,
                             input logic [7:0] a, input logic [7:0] b, input logic ci);
      int ua, ub, sa, sb, t, sr;
      ua = int'(a);
      ub = int'(b);
      sa = a[7] ? ua - 256 : ua;
      sb = b[7] ? ub - 256 : ub;
      if (r) begin
         m_s = 8'h00; m_c = 1'b0; m_o = 1'b0; m_v = 1'b0;
      end else if (iv) begin
         if (!op) begin
            t  = ua + ub + int'(ci);
            sr = sa + sb + int'(ci);
            m_c = (t >= 256);
         end else begin
            t  = ua - ub - int'(ci);
            sr = sa - sb - int'(ci);
            m_c = (ua < ub + int'(ci));
         end
         m_s = t[7:0];
         m_o = (sr > 127) || (sr < -128);
         m_v = 1'b1;
      end else begin
         m_v = 1'b0;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; op1 = 1'b0;
      iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; op8 = 1'b0;

      //           w  op  a      b      cin   s      cout  ovf
      vecs[0]  = '{1, 1'b0, 8'h0,  8'h0,  1'b0, 8'h0,  1'b0, 1'b0};
      vecs[1]  = '{1, 1'b0, 8'h0,  8'h1,  1'b0, 8'h1,  1'b0, 1'b0};
      vecs[2]  = '{1, 1'b0, 8'h1,  8'h1,  1'b0, 8'h0,  1'b1, 1'b1};
      vecs[3]  = '{1, 1'b0, 8'h1,  8'h1,  1'b1, 8'h1,  1'b1, 1'b0};
      vecs[4]  = '{1, 1'b1, 8'h0,  8'h1,  1'b0, 8'h1,  1'b1, 1'b1};
      vecs[5]  = '{1, 1'b1, 8'h1,  8'h0,  1'b1, 8'h0,  1'b0, 1'b1};
      vecs[6]  = '{1, 1'b1, 8'h0,  8'h0,  1'b1, 8'h1,  1'b1, 1'b0};
      vecs[7]  = '{1, 1'b1, 8'h1,  8'h1,  1'b1, 8'h1,  1'b1, 1'b0};
      vecs[8]  = '{8, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[9]  = '{8, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[10] = '{8, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[11] = '{8, 1'b1, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0};

      tick();
      tick();
      check("rst_s8", {24'h0, s8}, 32'h0);
      check("rst_cout8", {31'h0, cout8}, 32'h0);
      check("rst_ovf8", {31'h0, ovf8}, 32'h0);
      check("rst_vld8", {31'h0, ov8}, 32'h0);
      check("rst_vld1", {31'h0, ov1}, 32'h0);
      rst = 1'b0;

      // Directed table, one operation per cycle.
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].w == 1) begin
            iv1 = 1'b1; op1 = vecs[i].op; a1 = vecs[i].a[0]; b1 = vecs[i].b[0]; cin1 = vecs[i].cin;
            iv8 = 1'b0;
         end else begin
            iv8 = 1'b1; op8 = vecs[i].op; a8 = vecs[i].a; b8 = vecs[i].b; cin8 = vecs[i].cin;
            iv1 = 1'b0;
         end
         tick();
         if (vecs[i].w == 1) begin
            check($sformatf("vec%0d_s", i),    {31'h0, s1},    {31'h0, vecs[i].s[0]});
            check($sformatf("vec%0d_cout", i), {31'h0, cout1}, {31'h0, vecs[i].cout});
            check($sformatf("vec%0d_ovf", i),  {31'h0, ovf1},  {31'h0, vecs[i].ovf});
            check($sformatf("vec%0d_vld", i),  {31'h0, ov1},   32'h1);
         end else begin
            check($sformatf("vec%0d_s", i),    {24'h0, s8},    {24'h0, vecs[i].s});
            check($sformatf("vec%0d_cout", i), {31'h0, cout8}, {31'h0, vecs[i].cout});
            check($sformatf("vec%0d_ovf", i),  {31'h0, ovf8},  {31'h0, vecs[i].ovf});
            check($sformatf("vec%0d_vld", i),  {31'h0, ov8},   32'h1);
         end
      end
      iv1 = 1'b0;

      // Hold: a result of 0x10 must survive idle cycles with changing operands.
      iv8 = 1'b1; op8 = 1'b0; a8 = 8'h08; b8 = 8'h08; cin8 = 1'b0;
      tick();
      check("hold_load_s", {24'h0, s8}, 32'h10);
      iv8 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); op8 = 1'($urandom);
         tick();
         check($sformatf("hold%0d_s", k),    {24'h0, s8},    32'h10);
         check($sformatf("hold%0d_cout", k), {31'h0, cout8}, 32'h0);
         check($sformatf("hold%0d_vld", k),  {31'h0, ov8},   32'h0);
      end

      // Reset wins over a valid operation on the same edge.
      rst = 1'b1; iv8 = 1'b1; op8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0;
      tick();
      check("rstmid_s",    {24'h0, s8},    32'h0);
      check("rstmid_cout", {31'h0, cout8}, 32'h0);
      check("rstmid_ovf",  {31'h0, ovf8},  32'h0);
      check("rstmid_vld",  {31'h0, ov8},   32'h0);
      rst = 1'b0; a8 = 8'h02; b8 = 8'h03;
      tick();
      check("post_rst_s",   {24'h0, s8},  32'h05);
      check("post_rst_vld", {31'h0, ov8}, 32'h1);

      // Randomized traffic against the reference model.
      model_step(1'b0, 1'b1, 1'b0, 8'h02, 8'h03, 1'b0);
      for (int k = 0; k < 1000; k++) begin
         rst  = ($urandom_range(0, 49) == 0);
         iv8  = 1'($urandom);
         op8  = 1'($urandom);
         a8   = 8'($urandom);
         b8   = 8'($urandom);
         cin8 = 1'($urandom);
         model_step(rst, iv8, op8, a8, b8, cin8);
         tick();
         check($sformatf("rnd%0d_s", k),    {24'h0, s8},    {24'h0, m_s});
         check($sformatf("rnd%0d_cout", k), {31'h0, cout8}, {31'h0, m_c});
         check($sformatf("rnd%0d_ovf", k),  {31'h0, ovf8},  {31'h0, m_o});
         check($sformatf("rnd%0d_vld", k),  {31'h0, ov8},   {31'h0, m_v});
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fas.md
# fas

Registered, parameterizable full adder/subtractor. Each cycle it computes either a + b + cin or a − b − cin over WIDTH bits, selected by s_op, and registers the sum/difference, carry/borrow-out and a signed-overflow flag. With the default WIDTH = 1 it behaves as a single-bit full adder/subtractor cell, and it is the arithmetic primitive used by wider datapath blocks.

## Interface
Parameters:
- WIDTH, default 1: operand and result width in bits; legal range ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands are valid this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in when adding, borrow-in when subtracting.
- s_op  input  1  0 = add, 1 = subtract.
- s  output  WIDTH  registered sum or difference.
- cout  output  1  registered carry-out (add) or borrow-out (subtract).
- ovf  output  1  registered two's-complement overflow.
- out_valid  output  1  s/cout/ovf hold a result computed from a valid input.

## Operation
- Add (s_op = 0): {cout, s} = a + b + cin, computed at WIDTH+1 bits.
- Subtract (s_op = 1):
  - s = (a − b − cin) mod 2^WIDTH.
  - cout = 1 iff a < b + cin (unsigned compare), i.e. a borrow out of the MSB.
- Structure: a ripple chain of WIDTH one-bit cells.
  - Add cell: s_i = a_i ^ b_i ^ c_i; c_(i+1) = majority(a_i, b_i, c_i).
  - Subtract cell: d_i = a_i ^ b_i ^ br_i; br_(i+1) = (~a_i & b_i) | (~(a_i ^ b_i) & br_i).
  - The chain input is cin.
- ovf = (carry or borrow into the MSB cell) XOR (carry or borrow out of the MSB cell). This is the signed overflow of the operation, including the cin contribution. For WIDTH = 1 the signed range is −1..0.
- Capture rules:
  - in_valid = 1: s, cout and ovf are loaded from the combinational result; out_valid ← 1.
  - in_valid = 0: s, cout and ovf hold their previous values; out_valid ← 0.
- No back-pressure. A new operation may be issued every cycle.
- X/Z on the inputs while in_valid = 0 must not propagate into the registers.

## Timing
- Latency: 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N; out_valid is high in the cycle that follows.
- Throughput: 1 operation per cycle.
- Reset: with rst = 1 at a rising edge, s = 0, cout = 0, ovf = 0 and out_valid = 0 after that edge. Reset has priority over in_valid.
- Reset mid-stream: an operation sampled on the same edge as rst is discarded. The first valid result after reset comes from the first in_valid edge with rst = 0.
- Switching s_op between consecutive cycles is legal. Each result depends only on the inputs sampled at its own edge.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH = 1, add, one operation per cycle, check after each edge:
  - (a, b, cin) = (0, 0, 0) → s = 0, cout = 0.
  - (0, 1, 0) → s = 1, cout = 0.
  - (1, 1, 0) → s = 0, cout = 1.
  - (1, 1, 1) → s = 1, cout = 1.
  - out_valid = 1 each cycle.
- WIDTH = 1, subtract:
  - (0, 1, 0) → s = 1, cout = 1.
  - (1, 0, 1) → s = 0, cout = 0.
  - (0, 0, 1) → s = 1, cout = 1.
  - (1, 1, 1) → s = 1, cout = 1.
- WIDTH = 8:
  - Add 0xFF + 0x01 + 0 → s = 0x00, cout = 1, ovf = 0.
  - Add 0x7F + 0x01 + 0 → s = 0x80, cout = 0, ovf = 1.
  - Subtract 0x80 − 0x01 − 0 → s = 0x7F, cout = 0, ovf = 1.
  - Subtract 0x05 − 0x05 − 1 → s = 0xFF, cout = 1, ovf = 0.
- Hold: after a valid add result s = 0x10, drive in_valid = 0 with changing a/b for 3 cycles → s stays 0x10 and out_valid = 0.
- Reset: assert rst for 1 cycle while in_valid = 1 with a = b = 0xFF → after the edge all outputs are 0. The next valid operation (0x02 + 0x03) → s = 0x05.
- Randomized: 1000 cycles of random a, b, cin, s_op and in_valid at WIDTH = 8, compared against a reference model using the 1-cycle latency rule.
